// File: rtl/sfifo_axis_reader_pkg.sv
// ----------------------------------------------------------------------------
// basic_axis_pkg
// Shared constants and helpers for the FIFO-to-AXI4-Stream reader.
//   OUT_BUF_DEPTH : entries in the output skid buffer (covers the FIFO's
//                   1-cycle registered read latency at full throughput)
//   occ_t         : buffer occupancy (0..OUT_BUF_DEPTH)
//   ptr_t         : buffer slot index
//   cnt_width()   : width of the beat counter for a given packet length
// ----------------------------------------------------------------------------
package basic_axis_pkg;

    localparam int unsigned OUT_BUF_DEPTH = 3;

    typedef logic [1:0] occ_t;
    typedef logic [1:0] ptr_t;

    // Beat counter width; a 1-beat packet still gets a 1-bit counter.
    function automatic int unsigned cnt_width(input int unsigned len);
        int unsigned w;
        w = $clog2(len);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sfifo_axis_reader_out_buf.sv
// ----------------------------------------------------------------------------
// axis_out_buf
// 3-entry circular buffer, order preserving, synchronous active-high reset.
//   clk        in   clock
//   reset      in   synchronous reset, discards all entries
//   push       in   write push_data at the tail this cycle
//   push_data  in   data to write
//   pop        in   remove the head entry this cycle (caller ensures occ != 0)
//   head_data  out  oldest entry (0 while reset state / empty at reset)
//   occ        out  number of buffered entries
// ----------------------------------------------------------------------------
module axis_out_buf
    import basic_axis_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output occ_t              occ
);

    logic [DATA_W-1:0] mem_q [OUT_BUF_DEPTH];
    ptr_t              wr_ptr_q, wr_ptr_d;
    ptr_t              rd_ptr_q, rd_ptr_d;
    occ_t              occ_q, occ_d;

    function automatic ptr_t next_ptr(input ptr_t p);
        return (p == ptr_t'(OUT_BUF_DEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = next_ptr(wr_ptr_q);
        if (pop)  rd_ptr_d = next_ptr(rd_ptr_q);
        occ_d = occ_q + occ_t'(push) - occ_t'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < OUT_BUF_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push) mem_q[wr_ptr_q] <= push_data;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign occ       = occ_q;

endmodule

// File: rtl/sfifo_axis_reader.sv
// ----------------------------------------------------------------------------
// sfifo_axis_reader
// Drains a synchronous FIFO (1-cycle registered read) into an AXI4-Stream
// master with beat-count TLAST framing.
//   clk            in   clock shared with the FIFO
//   reset          in   synchronous active-high reset shared with the FIFO
//   fifo_rd_en     out  pop request (no combinational path from tready)
//   fifo_out       in   FIFO read data, valid the cycle after a pop
//   fifo_empty     in   FIFO empty flag
//   m_axis_tdata   out  stream data
//   m_axis_tvalid  out  stream valid
//   m_axis_tready  in   stream ready
//   m_axis_tlast   out  last beat of a pkt_len-beat packet
// ----------------------------------------------------------------------------
module sfifo_axis_reader
    import basic_axis_pkg::*;
#(
    parameter int unsigned num_data_bits = 32,
    parameter int unsigned pkt_len       = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     fifo_rd_en,
    input  logic [num_data_bits-1:0] fifo_out,
    input  logic                     fifo_empty,
    output logic [num_data_bits-1:0] m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tlast
);

    localparam int unsigned    CW       = cnt_width(pkt_len);
    localparam logic [CW-1:0]  LAST_CNT = CW'(pkt_len - 1);

    logic          inflight_q;
    logic [CW-1:0] cnt_q, cnt_d;
    occ_t          occ;
    logic [2:0]    committed;
    logic          pop;

    axis_out_buf #(
        .DATA_W (num_data_bits)
    ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight_q),
        .push_data (fifo_out),
        .pop       (pop),
        .head_data (m_axis_tdata),
        .occ       (occ)
    );

    // Words already buffered plus the one arriving this cycle; only issue a
    // pop when a slot is guaranteed even if the consumer never accepts.
    assign committed  = {1'b0, occ} + {2'b00, inflight_q};
    assign fifo_rd_en = !reset && !fifo_empty && (committed < 3'(OUT_BUF_DEPTH));

    assign m_axis_tvalid = (occ != '0);
    assign pop           = m_axis_tvalid && m_axis_tready;
    assign m_axis_tlast  = (cnt_q == LAST_CNT);

    always_comb begin
        cnt_d = cnt_q;
        if (pop) cnt_d = m_axis_tlast ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            inflight_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            inflight_q <= fifo_rd_en;
            cnt_q      <= cnt_d;
        end
    end

endmodule

// File: tb/tb_sfifo_axis_reader.sv
module tb_sfifo_axis_reader;

    typedef struct packed {
        logic [31:0] d;
        logic        l;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    // Instance 0: pkt_len = 16
    logic        rd0, empty0, tv0, tr0, tl0;
    logic [31:0] fout0 = '0, td0;
    // Instance 1: pkt_len = 1
    logic        rd1, empty1, tv1, tr1, tl1;
    logic [31:0] fout1 = '0, td1;

    int          n_cmp = 0;
    int          n_fail = 0;

    logic [31:0] fq0[$], fq1[$];
    int          fcount0 = 0, fcount1 = 0;
    exp_t        exp0[$], exp1[$];
    int          idx0 = 0;

    // Outstanding-word tracking and stall-stability state for instance 0
    int          issued0 = 0, accepted0 = 0;
    logic        prev_stall0 = 1'b0;
    logic [31:0] prev_d0 = '0;
    logic        prev_l0 = 1'b0;

    always #5 clk = ~clk;

    assign empty0 = (fcount0 == 0);
    assign empty1 = (fcount1 == 0);

    sfifo_axis_reader #(.num_data_bits(32), .pkt_len(16)) dut0 (
        .clk(clk), .reset(reset), .fifo_rd_en(rd0), .fifo_out(fout0),
        .fifo_empty(empty0), .m_axis_tdata(td0), .m_axis_tvalid(tv0),
        .m_axis_tready(tr0), .m_axis_tlast(tl0));

    sfifo_axis_reader #(.num_data_bits(32), .pkt_len(1)) dut1 (
        .clk(clk), .reset(reset), .fifo_rd_en(rd1), .fifo_out(fout1),
        .fifo_empty(empty1), .m_axis_tdata(td1), .m_axis_tvalid(tv1),
        .m_axis_tready(tr1), .m_axis_tlast(tl1));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Behavioural FIFOs with 1-cycle registered read
    always @(posedge clk) begin
        if (reset) begin
            fq0.delete(); fcount0 = 0; fout0 <= '0;
            fq1.delete(); fcount1 = 0; fout1 <= '0;
        end else begin
            if (rd0 && fcount0 > 0) begin fout0 <= fq0.pop_front(); fcount0--; end
            if (rd1 && fcount1 > 0) begin fout1 <= fq1.pop_front(); fcount1--; end
        end
    end

    // Scoreboard / protocol monitor
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            issued0 = 0; accepted0 = 0; prev_stall0 = 1'b0;
        end else begin
            if (prev_stall0) begin
                chk("stall_valid", {63'd0, tv0}, 64'd1);
                chk("stall_data", {32'd0, td0}, {32'd0, prev_d0});
                chk("stall_last", {63'd0, tl0}, {63'd0, prev_l0});
            end
            if (rd0) issued0++;
            if (tv0 && tr0) begin
                accepted0++;
                if (exp0.size() == 0) begin
                    chk("unexpected_beat0", {32'd0, td0}, 64'hDEAD_BEEF_DEAD_BEEF);
                end else begin
                    e = exp0.pop_front();
                    chk("beat0_data", {32'd0, td0}, {32'd0, e.d});
                    chk("beat0_last", {63'd0, tl0}, {63'd0, e.l});
                end
            end
            n_cmp++;
            assert (issued0 - accepted0 <= 3) else begin
                n_fail++;
                $error("FAIL occupancy: observed %0d expected <= 3", issued0 - accepted0);
            end
            prev_stall0 = tv0 && !tr0;
            prev_d0     = td0;
            prev_l0     = tl0;
            if (tv1 && tr1) begin
                if (exp1.size() == 0) begin
                    chk("unexpected_beat1", {32'd0, td1}, 64'hDEAD_BEEF_DEAD_BEEF);
                end else begin
                    e = exp1.pop_front();
                    chk("beat1_data", {32'd0, td1}, {32'd0, e.d});
                    chk("beat1_last", {63'd0, tl1}, {63'd0, e.l});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push0(input logic [31:0] d);
        exp_t e;
        e.d = d;
        e.l = ((idx0 % 16) == 15);
        exp0.push_back(e);
        fq0.push_back(d);
        fcount0++;
        idx0++;
    endtask

    task automatic drain0(input string tag, input int budget);
        logic done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            tick();
            if (exp0.size() == 0 && fcount0 == 0 && !tv0) done = 1'b1;
        end
        chk(tag, {63'd0, done}, 64'd1);
    endtask

    initial begin
        exp_t e1;
        int   pulses;
        logic [1:0] pat;
        tr0 = 1'b1;
        tr1 = 1'b1;
        reset = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_tvalid", {63'd0, tv0}, 64'd0);
        chk("rst_rden", {63'd0, rd0}, 64'd0);
        chk("rst_tdata", {32'd0, td0}, 64'd0);
        chk("rst_tlast1", {63'd0, tl1}, 64'd1);
        tick();
        reset = 1'b0;

        // Idle: empty FIFO for 20 cycles
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_rden", {63'd0, rd0}, 64'd0);
            chk("idle_tvalid", {63'd0, tv0}, 64'd0);
        end

        // 16 words, tready high: latency and back-to-back beats
        tick();
        for (int i = 0; i < 16; i++) push0(32'(i));
        @(negedge clk);
        chk("lat_rden_N", {63'd0, rd0}, 64'd1);
        chk("lat_tvalid_N", {63'd0, tv0}, 64'd0);
        @(negedge clk);
        chk("lat_tvalid_N1", {63'd0, tv0}, 64'd0);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("thru_tvalid", {63'd0, tv0}, 64'd1);
        end
        drain0("drain_burst", 20);

        // 32 words with tready pattern 1,0,0,1
        for (int i = 0; i < 32; i++) push0(32'h100 + 32'(i));
        begin
            logic done;
            done = 1'b0;
            for (int c = 0; c < 300 && !done; c++) begin
                pat = 2'(c % 4);
                tr0 = (pat == 2'd0) || (pat == 2'd3);
                tick();
                if (exp0.size() == 0 && fcount0 == 0 && !tv0) done = 1'b1;
            end
            chk("drain_toggle", {63'd0, done}, 64'd1);
        end
        tr0 = 1'b1;

        // Backpressure: 8 words, tready low
        tr0 = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) push0(32'h200 + 32'(i));
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rd0) pulses++;
        end
        chk("bp_pulses", 64'(pulses), 64'd3);
        chk("bp_tvalid", {63'd0, tv0}, 64'd1);
        chk("bp_tdata", {32'd0, td0}, 64'h200);
        chk("bp_fifo_left", 64'(fcount0), 64'd5);
        tick();
        tr0 = 1'b1;
        drain0("drain_bp", 40);

        // pkt_len=1 instance: every beat is last
        for (int i = 0; i < 4; i++) begin
            e1.d = 32'hA + 32'(i);
            e1.l = 1'b1;
            exp1.push_back(e1);
            fq1.push_back(e1.d);
            fcount1++;
        end
        begin
            logic done;
            done = 1'b0;
            for (int c = 0; c < 20 && !done; c++) begin
                tick();
                if (exp1.size() == 0 && fcount1 == 0 && !tv1) done = 1'b1;
            end
            chk("drain_pkt1", {63'd0, done}, 64'd1);
        end

        // Reset with 2 words buffered and 1 in flight
        tr0 = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) push0(32'h300 + 32'(i));
        tick();
        tick();
        tick();
        @(negedge clk);
        chk("pre_rst_tvalid", {63'd0, tv0}, 64'd1);
        chk("pre_rst_issued", 64'(issued0 - accepted0), 64'd3);
        reset = 1'b1;
        exp0.delete();
        idx0 = 0;
        tick();
        @(negedge clk);
        chk("mid_rst_tvalid", {63'd0, tv0}, 64'd0);
        tick();
        reset = 1'b0;
        tr0 = 1'b1;
        @(negedge clk);
        chk("post_rst_tvalid", {63'd0, tv0}, 64'd0);
        tick();
        for (int i = 0; i < 16; i++) push0(32'h55 + 32'(i));
        repeat (2) @(negedge clk);
        @(negedge clk);
        chk("refill_first", {32'd0, td0}, 64'h55);
        chk("refill_first_last", {63'd0, tl0}, 64'd0);
        drain0("drain_refill", 40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
